// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word receiver and the downstream packet decoders.
package spi_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2
  } spi_state_t;

  localparam logic [1:0] PKT_SCORE   = 2'b00;
  localparam logic [1:0] PKT_TIMER   = 2'b01;
  localparam logic [1:0] PKT_OCTAGON = 2'b11;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input, async reset to RST_VAL.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic pxl_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // synchronizer chain
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_word_receiver.sv
// SPI slave front end: synchronized, framed, bit-counted 32-bit word reception in pxl_clk.
// Optional frame error counter enabled by defining SPI_WORD_RX_ERRCNT_EN.
module spi_word_receiver
  import spi_pkg::*;
#(
  parameter int WORD_BITS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                 pxl_clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 sdi,
  input  logic                 ss_b,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic [1:0]           word_type,
  output logic                 busy,
  output logic [ERR_W-1:0]     frame_err_count
);

  localparam int CNT_W = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic sck_sync_s, sdi_sync_s, ssb_sync_s;
  logic sck_prev_r, fall_s;
  logic [SYNC_STAGES-1:0] primed_r;
  logic primed_s;

  spi_state_t state_r, state_nxt;
  logic [WORD_BITS-1:0] shift_r, shift_nxt, word_r;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt;
  logic [1:0]           type_r;
  logic                 valid_r, busy_r, load_s;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .pxl_clk(pxl_clk), .reset(reset), .d(sck), .q(sck_sync_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .pxl_clk(pxl_clk), .reset(reset), .d(sdi), .q(sdi_sync_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssb (
    .pxl_clk(pxl_clk), .reset(reset), .d(ss_b), .q(ssb_sync_s));

  assign fall_s   = sck_prev_r & ~sck_sync_s;
  // ss_b_sync shows its reset value until the chain has flushed; RESYNC must not trust it before then.
  assign primed_s = primed_r[SYNC_STAGES-1];

  // edge detect history, synchronizer flush tracker and state register
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      sck_prev_r <= 1'b0;
      primed_r   <= {SYNC_STAGES{1'b0}};
      state_r    <= RESYNC;
      shift_r    <= {WORD_BITS{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      sck_prev_r <= sck_sync_s;
      primed_r   <= {primed_r[SYNC_STAGES-2:0], 1'b1};
      state_r    <= state_nxt;
      shift_r    <= shift_nxt;
      cnt_r      <= cnt_nxt;
    end
  end

  // next-state, shifting and bit counting; a coincident fall is applied before the ss_b rise
  always_comb begin
    state_nxt = state_r;
    shift_nxt = shift_r;
    cnt_nxt   = cnt_r;
    load_s    = 1'b0;
    case (state_r)
      RESYNC: begin
        if (primed_s && ssb_sync_s) state_nxt = IDLE;
        else                        state_nxt = RESYNC;
      end
      IDLE: begin
        shift_nxt = {WORD_BITS{1'b0}};
        cnt_nxt   = {CNT_W{1'b0}};
        if (!ssb_sync_s) state_nxt = SHIFT;
        else             state_nxt = IDLE;
      end
      SHIFT: begin
        if (fall_s) begin
          shift_nxt = {shift_r[WORD_BITS-2:0], sdi_sync_s};
          if (cnt_r == LAST_BIT) begin
            load_s  = 1'b1;
            cnt_nxt = {CNT_W{1'b0}};
          end else begin
            cnt_nxt = cnt_r + CNT_W'(1);
          end
        end else begin
          shift_nxt = shift_r;
          cnt_nxt   = cnt_r;
        end
        if (ssb_sync_s) state_nxt = IDLE;
        else            state_nxt = SHIFT;
      end
      default: state_nxt = RESYNC;
    endcase
  end

  // registered word outputs
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      word_r  <= {WORD_BITS{1'b0}};
      type_r  <= 2'b00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= load_s;
      busy_r  <= (state_nxt == SHIFT);
      if (load_s) begin
        word_r <= shift_nxt;
        type_r <= shift_nxt[WORD_BITS-1:WORD_BITS-2];
      end
    end
  end

`ifdef SPI_WORD_RX_ERRCNT_EN
  logic [ERR_W-1:0] err_r;
  logic             abort_s;

  assign abort_s = (state_r == SHIFT) && ssb_sync_s && (cnt_nxt != {CNT_W{1'b0}});

  // saturating count of frames closed on a partial word
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      err_r <= {ERR_W{1'b0}};
    end else if (abort_s && (err_r != {ERR_W{1'b1}})) begin
      err_r <= err_r + ERR_W'(1);
    end
  end

  assign frame_err_count = err_r;
`else
  assign frame_err_count = {ERR_W{1'b0}};
`endif

  assign word       = word_r;
  assign word_type  = type_r;
  assign word_valid = valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Directed self-checking bench for spi_word_receiver.
module tb_spi_word_receiver;

  logic        pxl_clk = 1'b0;
  logic        reset;
  logic        sck, sdi, ss_b;
  logic [31:0] word;
  logic        word_valid;
  logic [1:0]  word_type;
  logic        busy;
  logic [7:0]  frame_err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int valid_cyc = 0;
  int fall_cyc = 0;
  logic [31:0] cap_word [0:7];
  logic [1:0]  cap_type [0:7];

  spi_word_receiver dut (
    .pxl_clk(pxl_clk), .reset(reset), .sck(sck), .sdi(sdi), .ss_b(ss_b),
    .word(word), .word_valid(word_valid), .word_type(word_type),
    .busy(busy), .frame_err_count(frame_err_count)
  );

  always #5 pxl_clk = ~pxl_clk;

  always @(posedge pxl_clk) cyc++;

  always @(negedge pxl_clk) begin
    if (word_valid) begin
      if (pulses < 8) begin
        cap_word[pulses] = word;
        cap_type[pulses] = word_type;
      end
      pulses++;
      valid_cyc = cyc;
    end
  end

  function automatic logic [7:0] exp_err(input int n);
`ifdef SPI_WORD_RX_ERRCNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pxl_clk);
  endtask

  // n MSB-first bits of data; optionally raise ss_b together with the last fall
  task automatic send_bits(input logic [31:0] data, input int n, input bit raise_on_last);
    for (int i = 0; i < n; i++) begin
      sdi = data[31-i];
      sck = 1'b1;
      wait_cycles(4);
      sck = 1'b0;
      fall_cyc = cyc;
      if (raise_on_last && (i == n - 1)) ss_b = 1'b1;
      wait_cycles(4);
    end
  endtask

  task automatic open_frame();
    ss_b = 1'b0;
    wait_cycles(4);
  endtask

  task automatic close_frame();
    wait_cycles(4);
    ss_b = 1'b1;
    wait_cycles(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; ss_b = 1'b1;
    wait_cycles(3);
    checks++;
    if (word !== 32'h0 || word_valid !== 1'b0 || word_type !== 2'b00 ||
        busy !== 1'b0 || frame_err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: word=%h valid=%b type=%b busy=%b err=%h, required all zero",
               word, word_valid, word_type, busy, frame_err_count);
    end
    reset = 1'b0;
    wait_cycles(6);
    checks++;
    if (busy !== 1'b0 || pulses != 0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b pulses=%0d, required 0/0", busy, pulses);
    end
  endtask

  task automatic test_single_word();
    pulses = 0;
    open_frame();
    send_bits(32'hC0FF_EE01, 31, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: got %b required 1", busy);
    end
    send_bits(32'hC0FF_EE01 << 31, 1, 1'b0);
    close_frame();
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_pulses: got %0d required 1", pulses);
    end
    checks++;
    if (cap_word[0] !== 32'hC0FF_EE01 || cap_type[0] !== 2'b11) begin
      errors++;
      $display("FAIL single_word: got %h/%b required c0ffee01/11", cap_word[0], cap_type[0]);
    end
    checks++;
    if ((valid_cyc - fall_cyc) < 3 || (valid_cyc - fall_cyc) > 4) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles required 3..4", valid_cyc - fall_cyc);
    end
    checks++;
    if (word !== 32'hC0FF_EE01 || frame_err_count !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: word=%h err=%h busy=%b required c0ffee01/00/0",
               word, frame_err_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    open_frame();
    send_bits(32'h4123_4567, 32, 1'b0);
    send_bits(32'h0000_00FF, 32, 1'b0);
    close_frame();
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (cap_word[0] !== 32'h4123_4567 || cap_type[0] !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b required 41234567/01", cap_word[0], cap_type[0]);
    end
    checks++;
    if (cap_word[1] !== 32'h0000_00FF || cap_type[1] !== 2'b00 || frame_err_count !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b err=%h required 000000ff/00 err=00",
               cap_word[1], cap_type[1], frame_err_count);
    end
  endtask

  task automatic test_abort();
    pulses = 0;
    open_frame();
    send_bits(32'hFFFF_FFFF, 17, 1'b0);
    close_frame();
    checks++;
    if (pulses != 0 || frame_err_count !== exp_err(1)) begin
      errors++;
      $display("FAIL abort_partial: pulses=%0d err=%h required 0/%h",
               pulses, frame_err_count, exp_err(1));
    end
    open_frame();
    send_bits(32'h8000_0001, 32, 1'b0);
    close_frame();
    checks++;
    if (pulses != 1 || cap_word[0] !== 32'h8000_0001 || cap_type[0] !== 2'b10 ||
        frame_err_count !== exp_err(1)) begin
      errors++;
      $display("FAIL abort_next_word: pulses=%0d word=%h type=%b err=%h required 1/80000001/10/%h",
               pulses, cap_word[0], cap_type[0], frame_err_count, exp_err(1));
    end
  endtask

  task automatic test_simultaneous();
    pulses = 0;
    open_frame();
    send_bits(32'hA5A5_5A5A, 32, 1'b1);
    wait_cycles(6);
    checks++;
    if (pulses != 1 || cap_word[0] !== 32'hA5A5_5A5A || frame_err_count !== exp_err(1)) begin
      errors++;
      $display("FAIL simultaneous_close: pulses=%0d word=%h err=%h required 1/a5a55a5a/%h",
               pulses, cap_word[0], frame_err_count, exp_err(1));
    end
  endtask

  task automatic test_reset_mid_frame();
    pulses = 0;
    open_frame();
    send_bits(32'hFFFF_FFFF, 10, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (word !== 32'h0 || busy !== 1'b0 || frame_err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_clear: word=%h busy=%b err=%h required 0/0/0",
               word, busy, frame_err_count);
    end
    wait_cycles(2);
    reset = 1'b0;
    send_bits(32'hFFFF_FFFF, 32, 1'b0);
    send_bits(32'h1234_5678, 32, 1'b0);
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resync: pulses=%0d busy=%b required 0/0", pulses, busy);
    end
    close_frame();
    open_frame();
    send_bits(32'h1234_5678, 32, 1'b0);
    close_frame();
    checks++;
    if (pulses != 1 || cap_word[0] !== 32'h1234_5678 || cap_type[0] !== 2'b00 ||
        frame_err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_fresh: pulses=%0d word=%h type=%b err=%h required 1/12345678/00/00",
               pulses, cap_word[0], cap_type[0], frame_err_count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 254; i++) begin
      ss_b = 1'b0; wait_cycles(4);
      send_bits(32'h8000_0000, 1, 1'b0);
      ss_b = 1'b1; wait_cycles(4);
    end
    checks++;
    if (frame_err_count !== exp_err(254)) begin
      errors++;
      $display("FAIL sat_before: got %h required %h", frame_err_count, exp_err(254));
    end
    for (int i = 0; i < 46; i++) begin
      ss_b = 1'b0; wait_cycles(4);
      send_bits(32'h8000_0000, 1, 1'b0);
      ss_b = 1'b1; wait_cycles(4);
    end
    checks++;
    if (frame_err_count !== exp_err(300)) begin
      errors++;
      $display("FAIL sat_after: got %h required %h", frame_err_count, exp_err(300));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_simultaneous();
    test_reset_mid_frame();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
